// File: rtl/fifo_ctrl_pkg.sv
// rtl/fifo_ctrl_pkg.sv - fifo controller interface types for the load path
package fifo_ctrl_pkg;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } load_req_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] data;
    logic        err;
  } load_resp_t;

endpackage

// File: rtl/tri_pkg.sv
// rtl/tri_pkg.sv - TRI request/response channel types shared by load and store units
package tri_pkg;

  typedef enum logic [2:0] {
    TRI_LOAD_RQ  = 3'd0,
    TRI_STORE_RQ = 3'd1,
    TRI_AMO_RQ   = 3'd2
  } tri_req_type_e;

  typedef struct packed {
    logic          req_valid;
    tri_req_type_e req_type;
    logic [2:0]    req_size;
    logic [63:0]   req_addr;
    logic [63:0]   req_data;
    logic [3:0]    req_amo_op;
    logic          resp_ack;
  } tri_req_t;

  typedef struct packed {
    logic          req_ack;
    logic          resp_val;
    logic [127:0]  resp_data;
  } tri_resp_t;

endpackage

// File: rtl/load_unit_top.sv
// rtl/load_unit_top.sv - single-outstanding TRI load unit; response watchdog under LOAD_UNIT_TIMEOUT_EN
module load_unit_top
  import fifo_ctrl_pkg::*;
  import tri_pkg::*;
#(
  parameter logic [2:0] REQ_SIZE       = 3'h3,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  load_req_t  ld_req_i,
  output logic       ld_req_ready_o,
  output load_resp_t ld_resp_o,
  input  logic       ld_resp_ready_i,
  output tri_req_t   tri_req,
  input  tri_resp_t  tri_resp
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_OUT} state_e;

  state_e      state;
  logic [63:0] addr_q;
  logic [63:0] data_q;
  logic [63:0] resp_word;

  // The TRI line is 128 bits; address bit 3 picks the 64-bit half.
  assign resp_word = addr_q[3] ? tri_resp.resp_data[127:64] : tri_resp.resp_data[63:0];

`ifdef LOAD_UNIT_TIMEOUT_EN
  localparam int               CNT_W     = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] to_cnt;
  logic             err_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      addr_q <= '0;
      data_q <= '0;
`ifdef LOAD_UNIT_TIMEOUT_EN
      err_q  <= 1'b0;
      to_cnt <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (ld_req_i.valid) begin
            addr_q <= ld_req_i.addr;
`ifdef LOAD_UNIT_TIMEOUT_EN
            err_q  <= 1'b0;
`endif
            state  <= S_REQ;
          end
        end
        S_REQ: begin
          if (tri_resp.req_ack) begin
`ifdef LOAD_UNIT_TIMEOUT_EN
            to_cnt <= '0;
`endif
            state  <= S_RESP;
          end
        end
        S_RESP: begin
          // A response arriving on the limit cycle still wins over the watchdog.
          if (tri_resp.resp_val) begin
            data_q <= resp_word;
            state  <= S_OUT;
          end
`ifdef LOAD_UNIT_TIMEOUT_EN
          else if (to_cnt == CNT_LIMIT) begin
            data_q <= '0;
            err_q  <= 1'b1;
            state  <= S_OUT;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        S_OUT: begin
          if (ld_resp_ready_i) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign ld_req_ready_o = (state == S_IDLE);

  always_comb begin
    ld_resp_o       = '0;
    ld_resp_o.valid = (state == S_OUT);
    ld_resp_o.data  = data_q;
`ifdef LOAD_UNIT_TIMEOUT_EN
    ld_resp_o.err   = err_q;
`else
    ld_resp_o.err   = 1'b0;
`endif
  end

  always_comb begin
    tri_req            = '0;
    tri_req.req_valid  = (state == S_REQ);
    tri_req.req_type   = TRI_LOAD_RQ;
    tri_req.req_size   = REQ_SIZE;
    tri_req.req_addr   = addr_q;
    tri_req.req_data   = '0;
    tri_req.req_amo_op = '0;
    tri_req.resp_ack   = (state == S_RESP);
  end

  a_timeout_cfg: assert property (@(posedge clk) TIMEOUT_CYCLES >= 2);

  // A response before the request is acked breaks the TRI protocol.
  a_no_early_resp: assert property (@(posedge clk) disable iff (!rst_n)
    !(state == S_REQ && tri_resp.resp_val));

endmodule

// File: tb/tb_load_unit_top.sv
// tb/tb_load_unit_top.sv - directed bench with a transaction-level model for load_unit_top
`timescale 1ns/1ps
module tb_load_unit_top;
  import fifo_ctrl_pkg::*;
  import tri_pkg::*;

  localparam int          TO   = 16;
  localparam logic [63:0] LO_W = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] HI_W = 64'hBBBB_BBBB_BBBB_BBBB;
`ifdef LOAD_UNIT_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  load_req_t  ld_req;
  logic       ld_req_ready;
  load_resp_t ld_resp;
  logic       ld_resp_ready;
  tri_req_t   tri_req;
  tri_resp_t  tri_resp;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  load_unit_top #(.REQ_SIZE(3'h3), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_req_i(ld_req), .ld_req_ready_o(ld_req_ready),
    .ld_resp_o(ld_resp), .ld_resp_ready_i(ld_resp_ready),
    .tri_req(tri_req), .tri_resp(tri_resp)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // TRI responder: acks after ack_dly request cycles, answers resp_dly cycles later
  int           ack_dly = 0, resp_dly = 0;
  bit           resp_en = 1'b1;
  logic [127:0] rsp_data = '0;
  int           rsp_phase = 0, rsp_cnt = 0;

  initial begin
    tri_resp = '0;
    forever begin
      @(negedge clk);
      tri_resp.req_ack  = 1'b0;
      tri_resp.resp_val = 1'b0;
      if (!rst_n) begin
        rsp_phase = 0;
        rsp_cnt   = 0;
      end else if (rsp_phase == 0) begin
        if (tri_req.req_valid) begin
          if (rsp_cnt == ack_dly) begin
            tri_resp.req_ack = 1'b1;
            rsp_phase = 1;
            rsp_cnt   = 0;
          end else rsp_cnt++;
        end
      end else if (resp_en) begin
        if (rsp_cnt == resp_dly) begin
          tri_resp.resp_val  = 1'b1;
          tri_resp.resp_data = rsp_data;
          rsp_phase = 0;
          rsp_cnt   = 0;
        end else rsp_cnt++;
      end
    end
  end

  // Transaction model: one load at a time, tracked as busy/acked/done
  bit          m_busy = 0, m_acked = 0, m_done = 0, m_err = 0;
  int          m_wait = 0, m_reqs = 0;
  logic [63:0] m_addr = '0, m_data = '0;

  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      m_busy = 0; m_acked = 0; m_done = 0;
    end else if (!m_busy) begin
      if (ld_req.valid) begin
        m_busy = 1; m_acked = 0; m_done = 0; m_reqs = 0; m_addr = ld_req.addr;
      end
    end else begin
      if (tri_req.req_valid && tri_resp.req_ack) m_reqs++;
      if (!m_acked) begin
        if (tri_resp.req_ack) begin m_acked = 1; m_wait = 0; end
      end else if (!m_done) begin
        if (tri_resp.resp_val) begin
          m_done = 1; m_err = 0;
          m_data = m_addr[3] ? tri_resp.resp_data[127:64] : tri_resp.resp_data[63:0];
        end else if (TIMEOUT_ON && m_wait == TO - 1) begin
          m_done = 1; m_err = 1; m_data = '0;
        end else m_wait++;
      end else if (ld_resp_ready) begin
        chk("req_count", 64'(m_reqs), 64'd1);
        m_busy = 0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("ld_req_ready", 64'(ld_req_ready), 64'(!m_busy));
      chk("req_valid", 64'(tri_req.req_valid), 64'(m_busy && !m_acked));
      chk("resp_ack", 64'(tri_req.resp_ack), 64'(m_busy && m_acked && !m_done));
      chk("ld_resp_valid", 64'(ld_resp.valid), 64'(m_busy && m_done));
      if (tri_req.req_valid) begin
        chk("req_addr", tri_req.req_addr, m_addr);
        chk("req_type", 64'(tri_req.req_type), 64'(TRI_LOAD_RQ));
        chk("req_size", 64'(tri_req.req_size), 64'h3);
        chk("req_data", tri_req.req_data, 64'h0);
        chk("req_amo_op", 64'(tri_req.req_amo_op), 64'h0);
      end
      if (ld_resp.valid) begin
        chk("ld_resp_data", ld_resp.data, m_data);
        chk("ld_resp_err", 64'(ld_resp.err), 64'(m_err));
      end
    end
  end

  task automatic start_load(input logic [63:0] a, input int ad, input int rd, input bit re,
                            output int acc_cyc);
    @(posedge clk);
    #1;
    ack_dly = ad; resp_dly = rd; resp_en = re; rsp_phase = 0; rsp_cnt = 0;
    @(negedge clk);
    ld_req.valid = 1'b1;
    ld_req.addr  = a;
    acc_cyc      = cyc;
    @(negedge clk);
    ld_req.valid = 1'b0;
  endtask

  task automatic wait_valid(input string name, output int vcyc);
    bit seen = 0;
    vcyc = -1;
    for (int i = 0; i < 200; i++) begin
      if (ld_resp.valid) begin seen = 1; vcyc = cyc; break; end
      @(negedge clk);
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s: ld_resp_o.valid never rose within 200 cycles", name);
    end
  endtask

  int acc, vc;

  initial begin
    rst_n = 1'b0;
    ld_req = '0;
    ld_resp_ready = 1'b1;
    rsp_data = {HI_W, LO_W};
    repeat (3) @(negedge clk);
    chk("rst_ld_req_ready", 64'(ld_req_ready), 64'd1);
    chk("rst_resp_valid", 64'(ld_resp.valid), 64'd0);
    chk("rst_req_valid", 64'(tri_req.req_valid), 64'd0);
    chk("rst_resp_ack", 64'(tri_req.resp_ack), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // basic lower-word load
    start_load(64'h1000, 0, 0, 1'b1, acc);
    wait_valid("basic", vc);
    chk("basic_latency", 64'(vc - acc), 64'd3);
    chk("basic_data", ld_resp.data, LO_W);
    chk("basic_err", 64'(ld_resp.err), 64'd0);
    repeat (2) @(negedge clk);

    // upper word, with request fields pinned
    start_load(64'h1008, 0, 0, 1'b1, acc);
    chk("upper_req_addr", tri_req.req_addr, 64'h1008);
    chk("upper_req_size", 64'(tri_req.req_size), 64'h3);
    chk("upper_req_type", 64'(tri_req.req_type), 64'(TRI_LOAD_RQ));
    wait_valid("upper", vc);
    chk("upper_data", ld_resp.data, HI_W);
    repeat (2) @(negedge clk);

    // stalled ack and response
    start_load(64'h2000, 5, 7, 1'b1, acc);
    wait_valid("stall", vc);
    chk("stall_latency", 64'(vc - acc), 64'd15);
    chk("stall_data", ld_resp.data, LO_W);
    repeat (2) @(negedge clk);

    // backpressure with a second request waiting
    ld_resp_ready = 1'b0;
    start_load(64'h3008, 0, 0, 1'b1, acc);
    wait_valid("bp", vc);
    ld_req.valid = 1'b1;
    ld_req.addr  = 64'h4000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 64'(ld_resp.valid), 64'd1);
      chk("bp_hold_data", ld_resp.data, HI_W);
      chk("bp_no_accept", 64'(ld_req_ready), 64'd0);
    end
    ld_resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_idle_after_hs", 64'(ld_req_ready), 64'd1);
    @(negedge clk);
    ld_req.valid = 1'b0;
    wait_valid("bp_second", vc);
    chk("bp_second_data", ld_resp.data, LO_W);
    repeat (2) @(negedge clk);

    // reset while waiting for the response
    start_load(64'h5000, 0, 0, 1'b0, acc);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_ld_req_ready", 64'(ld_req_ready), 64'd1);
    chk("midrst_req_valid", 64'(tri_req.req_valid), 64'd0);
    chk("midrst_resp_ack", 64'(tri_req.resp_ack), 64'd0);
    chk("midrst_resp_valid", 64'(ld_resp.valid), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    start_load(64'h6008, 0, 0, 1'b1, acc);
    wait_valid("after_rst", vc);
    chk("after_rst_data", ld_resp.data, HI_W);
    repeat (2) @(negedge clk);

`ifdef LOAD_UNIT_TIMEOUT_EN
    start_load(64'h7000, 0, 0, 1'b0, acc);
    wait_valid("timeout", vc);
    chk("timeout_latency", 64'(vc - acc), 64'd18);
    chk("timeout_err", 64'(ld_resp.err), 64'd1);
    chk("timeout_data", ld_resp.data, 64'h0);
    repeat (2) @(negedge clk);

    start_load(64'h7008, 0, TO - 1, 1'b1, acc);
    wait_valid("limit_resp", vc);
    chk("limit_latency", 64'(vc - acc), 64'd18);
    chk("limit_err", 64'(ld_resp.err), 64'd0);
    chk("limit_data", ld_resp.data, HI_W);
    repeat (2) @(negedge clk);
`endif

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/load_unit_top.md
Name: load_unit_top

Overview:
- Read-side counterpart of the store unit.
- Accepts one load address from the fifo controller, issues a TRI_LOAD_RQ on the TRI interface, and waits for the TRI response.
- Extracts the addressed 64-bit word and presents it to the fifo controller with a valid/ready handshake.
- Non-pipelined, one outstanding load; an upstream arbiter spreads traffic across instances for thread concurrency.

Parameters:
- REQ_SIZE, 3'h3, TRI size code driven on req_size (8-byte load).
- TIMEOUT_CYCLES, 1024, response watchdog limit; used only with LOAD_UNIT_TIMEOUT_EN; must be ≥2.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous active-low
- ld_req_i  in  fifo_ctrl_pkg::load_req_t  {valid, addr[63:0]} load request from fifo controller
- ld_req_ready_o  out  1  request accepted when valid&&ready
- ld_resp_o  out  fifo_ctrl_pkg::load_resp_t  {valid, data[63:0], err} returned word
- ld_resp_ready_i  in  1  consumer accepts ld_resp_o when valid&&ready
- tri_req  out  tri_pkg::tri_req_t  TRI request channel
- tri_resp  in  tri_pkg::tri_resp_t  TRI response channel

Behaviour:
- Single clock, rst_n synchronous active-low, sampled at posedge clk.
- FSM states: S_IDLE, S_REQ, S_RESP, S_OUT. Registers: state, addr_q, data_q, err_q.
- Reset values: state=S_IDLE, addr_q/data_q=0, err_q=0.
- Output values after reset: ld_req_ready_o=1, ld_resp_o.valid=0, tri_req.req_valid=0, tri_req.resp_ack=0.
- Reset mid-operation aborts any in-flight load with no further TRI activity. The integrator must guarantee the TRI responder is also reset.
- S_IDLE:
  - ld_req_ready_o=1.
  - On ld_req_i.valid, latch addr, clear err_q, go to S_REQ.
- S_REQ:
  - req_valid=1, req_type=TRI_LOAD_RQ, req_size=REQ_SIZE, req_addr=addr_q, req_data=0, req_amo_op=0.
  - req_valid and address hold stable until tri_resp.req_ack; on ack go to S_RESP.
  - A resp_val here is a protocol violation: ignored, flagged by assertion.
- S_RESP:
  - resp_ack=1.
  - On tri_resp.resp_val, capture data_q = addr_q[3] ? resp_data[127:64] : resp_data[63:0], go to S_OUT.
- S_OUT:
  - ld_resp_o.valid=1, data=data_q, err=err_q.
  - On ld_resp_ready_i go to S_IDLE. Output holds stable under backpressure.
- Latency: request accepted at cycle N.
  - req_valid is first driven in N+1.
  - With req_ack in N+1 and resp_val in N+2, ld_resp_o.valid rises in N+3.
  - Minimum 4 cycles per load, counting the return to IDLE.
- ld_req_ready_o is low in every state except S_IDLE. There is no accept in the same cycle as the S_OUT handshake.
- ld_resp_o.valid is never asserted in the same cycle as a TRI response.
- Misaligned addr (addr[2:0]≠0) is not checked; lower bits pass through to req_addr.

Optional Feature:
- Macro: LOAD_UNIT_TIMEOUT_EN.
- Enabled:
  - A counter of width $clog2(TIMEOUT_CYCLES) clears on entry to S_RESP and increments each S_RESP cycle without resp_val.
  - When the count reaches TIMEOUT_CYCLES-1 with no resp_val, go to S_OUT with data_q=0 and err_q=1.
  - A resp_val in the same cycle as the limit wins: normal capture, err=0.
  - Any later stray resp_val is ignored (not acked, because resp_ack=0 outside S_RESP).
- Disabled: no counter; ld_resp_o.err is tied to 0; S_RESP waits indefinitely.

Decomposition:
- fifo_ctrl_pkg gains load_req_t and load_resp_t.
- tri_pkg is reused unchanged (TRI_LOAD_RQ, tri_req_t, tri_resp_t).
- State enum is local to the module.
- Word extraction by addr_q[3] is small enough to stay inline; no sub-module is needed.
- The bench uses a separate TRI responder model, not part of RTL.

Test Plan:
- Basic load: addr=0x1000, responder acks in 1 cycle, resp_data={64'hBBBB..., 64'hAAAA...}, ready_i=1 -> ld_resp_o.data=0xAAAA..., err=0, valid rises exactly 3 cycles after accept.
- Upper word: addr=0x1008, same resp_data -> data=0xBBBB...; req_addr=0x1008, req_size=3'h3, req_type=TRI_LOAD_RQ.
- Stalls: req_ack delayed 5 cycles and resp_val delayed 7 cycles -> req_valid/addr held stable throughout, exactly one request issued, correct data returned.
- Backpressure: ld_resp_ready_i low 10 cycles -> ld_resp_o stable, ld_req_ready_o=0, new ld_req_i.valid not accepted until after handshake.
- Reset mid-flight: assert rst_n=0 in S_RESP -> next cycle state IDLE, req_valid=0, resp_ack=0, ld_resp_o.valid=0, ld_req_ready_o=1.
- Timeout (LOAD_UNIT_TIMEOUT_EN, TIMEOUT_CYCLES=16): no resp_val -> ld_resp_o.valid with err=1, data=0 after 16 S_RESP cycles; second run with resp_val on the 16th S_RESP cycle -> err=0, data captured.
